// File: rtl/uart_rx_word_packer_if.sv
// Byte-in / word-out bundle between the UART receiver, the word packer and the loader.
// The packer uses the slave view; the receiver/loader side uses the master view.
interface uart_rx_word_packer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_ready;
  logic [7:0]    rdata;
  logic          ferr;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          err;
  logic          timeout;

  modport slave (
    input  rx_ready, rdata, ferr, word_ready,
    output word_valid, word_data, count, overflow, err, timeout
  );

  modport master (
    output rx_ready, rdata, ferr, word_ready,
    input  word_valid, word_data, count, overflow, err, timeout
  );
endinterface

// File: rtl/uart_rx_word_packer.sv
// Packs UART bytes into little-endian 32-bit words and queues them in a show-ahead FIFO.
// Optional partial-word idle timeout is built only when UART_PACK_TIMEOUT_EN is defined.
module uart_rx_word_packer #(
  parameter int DEPTH        = 8,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                clock,
  input  logic                reset,
  uart_rx_word_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          word_valid_q, word_valid_d;
  logic [31:0]   word_data_q, word_data_d;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  logic          accept_s;
  logic          complete_s;
  logic          pop_s;
  logic          push_s;
  logic          expire_s;
  logic [31:0]   push_word_s;

  // Handshake decode: bytes are refused from the first ferr cycle on.
  always_comb begin
    accept_s    = bus.rx_ready & ~bus.ferr & ~err_q;
    complete_s  = accept_s & (byte_cnt_q == 2'd3);
    push_word_s = {bus.rdata, shift_q};
    pop_s       = word_valid_q & bus.word_ready;
    push_s      = complete_s & ((count_q != CW'(DEPTH)) | pop_s);
  end

`ifdef UART_PACK_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  // Idle counter; an accepted byte in the expiry cycle suppresses the timeout.
  always_comb begin
    idle_d   = 32'd0;
    expire_s = 1'b0;
    if (accept_s || (byte_cnt_q == 2'd0)) begin
      idle_d = 32'd0;
    end else if (idle_q == 32'(TIMEOUT_CLKS - 1)) begin
      expire_s = 1'b1;
      idle_d   = 32'd0;
    end else begin
      idle_d = idle_q + 32'd1;
    end
  end

  // Idle counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      idle_q <= 32'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CLKS != 0);
  assign expire_s         = 1'b0;
`endif

  // Byte lane assembly and sticky error/overflow flags.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    err_d      = err_q;
    overflow_d = overflow_q;
    timeout_d  = expire_s;
    if (bus.ferr && !err_q) begin
      err_d      = 1'b1;
      byte_cnt_d = 2'd0;
      shift_d    = 24'd0;
    end else if (complete_s) begin
      byte_cnt_d = 2'd0;
      shift_d    = 24'd0;
      overflow_d = overflow_q | ~push_s;
    end else if (accept_s) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    shift_d[7:0]   = bus.rdata;
        2'd1:    shift_d[15:8]  = bus.rdata;
        2'd2:    shift_d[23:16] = bus.rdata;
        default: shift_d        = shift_q;
      endcase
    end else if (expire_s) begin
      byte_cnt_d = 2'd0;
      shift_d    = 24'd0;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  // FIFO bookkeeping; the head register is refreshed from the slot the next read pointer names.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(push_s);
    rd_ptr_d     = rd_ptr_q + AW'(pop_s);
    count_d      = count_q + CW'(push_s) - CW'(pop_s);
    word_valid_d = (count_d != CW'(0));
    if (push_s && (count_q == CW'(pop_s))) begin
      word_data_d = push_word_s;
    end else if (count_d != CW'(0)) begin
      word_data_d = mem_q[rd_ptr_d];
    end else begin
      word_data_d = 32'd0;
    end
  end

  // Word storage; stale contents are harmless because pointers and count reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'd0;
      wr_ptr_q     <= AW'(0);
      rd_ptr_q     <= AW'(0);
      count_q      <= CW'(0);
      word_valid_q <= 1'b0;
      word_data_q  <= 32'd0;
      overflow_q   <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      overflow_q   <= overflow_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.err        = err_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer: per-cycle vector table plus multi-cycle sequences.
module tb_uart_rx_word_packer;
  localparam int DEPTH = 8;
  localparam int TMO   = 50;
`ifdef UART_PACK_TIMEOUT_EN
  localparam int GAP = 30;
`else
  localparam int GAP = 60;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  uart_rx_word_packer_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_word_packer #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rx;
    logic [7:0]  data;
    logic        ferr;
    logic        wready;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ec;
    logic        eerr;
  } vec_t;

  vec_t tbl[18];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_ready = 1'b1;
    bus.rdata    = b;
    step();
    bus.rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] wval(input int k);
    return 32'hA5C3_0000 + 32'(k) * 32'h0000_0111;
  endfunction

  task automatic drain(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      chk("drain_valid", {31'd0, bus.word_valid}, 32'd1);
      chk("drain_data", bus.word_data, wval(first + i));
      bus.word_ready = 1'b1;
      step();
      bus.word_ready = 1'b0;
    end
    chk("drain_empty_count", {28'd0, bus.count}, 32'd0);
    chk("drain_empty_valid", {31'd0, bus.word_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int tpulses;
    int tfirst;
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.rx_ready   = 1'b0;
    bus.rdata      = 8'h00;
    bus.ferr       = 1'b0;
    bus.word_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_data", bus.word_data, 32'd0);
    chk("rst_count", {28'd0, bus.count}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout}, 32'd0);

    // back-to-back bytes, pop coincident with push, then framing error with a stored word
    tbl[0]  = '{1'b1, 8'h78, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'd0, 1'b0};
    tbl[2]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'd0, 1'b0};
    tbl[3]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 4'd1, 1'b0};
    tbl[4]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 4'd1, 1'b0};
    tbl[5]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 4'd1, 1'b0};
    tbl[6]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 4'd1, 1'b0};
    tbl[7]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 32'h0403_0201, 4'd1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b0};
    tbl[9]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b0};
    tbl[10] = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b0};
    tbl[11] = '{1'b1, 8'hCC, 1'b1, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b1};
    tbl[12] = '{1'b1, 8'hDD, 1'b1, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b1};
    tbl[13] = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b1};
    tbl[14] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b1};
    tbl[15] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 32'h0403_0201, 4'd1, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'd0, 1'b1};

    for (int v = 0; v < 18; v++) begin
      bus.rx_ready   = tbl[v].rx;
      bus.rdata      = tbl[v].data;
      bus.ferr       = tbl[v].ferr;
      bus.word_ready = tbl[v].wready;
      step();
      chk($sformatf("vec%0d_valid", v), {31'd0, bus.word_valid}, {31'd0, tbl[v].ev});
      chk($sformatf("vec%0d_data", v), bus.word_data, tbl[v].ed);
      chk($sformatf("vec%0d_count", v), {28'd0, bus.count}, {28'd0, tbl[v].ec});
      chk($sformatf("vec%0d_err", v), {31'd0, bus.err}, {31'd0, tbl[v].eerr});
    end
    bus.rx_ready   = 1'b0;
    bus.ferr       = 1'b0;
    bus.word_ready = 1'b0;
    chk("tbl_overflow", {31'd0, bus.overflow}, 32'd0);

    // spaced bytes: valid rises one cycle after the 4th pulse, consumer always ready
    do_reset();
    bus.word_ready = 1'b1;
    send_byte(8'h78);
    for (int g = 0; g < GAP; g++) step();
    send_byte(8'h56);
    for (int g = 0; g < GAP; g++) step();
    send_byte(8'h34);
    for (int g = 0; g < GAP; g++) step();
    chk("spaced_pre_valid", {31'd0, bus.word_valid}, 32'd0);
    send_byte(8'h12);
    chk("spaced_valid", {31'd0, bus.word_valid}, 32'd1);
    chk("spaced_data", bus.word_data, 32'h1234_5678);
    chk("spaced_count1", {28'd0, bus.count}, 32'd1);
    step();
    chk("spaced_count0", {28'd0, bus.count}, 32'd0);
    chk("spaced_valid0", {31'd0, bus.word_valid}, 32'd0);
    bus.word_ready = 1'b0;

    // overflow: 9 words into 8 slots, 9th dropped
    do_reset();
    for (int k = 0; k < 8; k++) send_word(wval(k));
    chk("full_count", {28'd0, bus.count}, 32'd8);
    chk("full_no_ovf", {31'd0, bus.overflow}, 32'd0);
    send_word(wval(8));
    chk("ovf_count", {28'd0, bus.count}, 32'd8);
    chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    drain(0, 8);
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

    // full FIFO, completing byte coincides with a pop
    do_reset();
    for (int k = 0; k < 8; k++) send_word(wval(k));
    for (int i = 0; i < 3; i++) send_byte(wval(8) >> (8 * i));
    bus.word_ready = 1'b1;
    send_byte(wval(8) >> 24);
    bus.word_ready = 1'b0;
    chk("fullpop_count", {28'd0, bus.count}, 32'd8);
    chk("fullpop_ovf", {31'd0, bus.overflow}, 32'd0);
    drain(1, 8);

    // idle partial word
    do_reset();
    send_byte(8'h11);
    tpulses = 0;
    tfirst  = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (bus.timeout === 1'b1) begin
        tpulses++;
        if (tfirst < 0) tfirst = c;
      end
    end
`ifdef UART_PACK_TIMEOUT_EN
    chk("tmo_pulses", 32'(tpulses), 32'd1);
    chk("tmo_cycle", 32'(tfirst), 32'(TMO));
    send_word(32'h0403_0201);
    chk("tmo_word", bus.word_data, 32'h0403_0201);
`else
    chk("notmo_pulses", 32'(tpulses), 32'd0);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    chk("notmo_word", bus.word_data, 32'h0403_0211);
`endif
    chk("idle_count", {28'd0, bus.count}, 32'd1);

    // reset mid-word with words queued
    do_reset();
    send_word(wval(20));
    send_word(wval(21));
    send_byte(8'hE1);
    send_byte(8'hE2);
    send_byte(8'hE3);
    chk("prerst_count", {28'd0, bus.count}, 32'd2);
    do_reset();
    chk("midrst_count", {28'd0, bus.count}, 32'd0);
    chk("midrst_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("midrst_err", {31'd0, bus.err}, 32'd0);
    chk("midrst_data", bus.word_data, 32'd0);
    send_word(32'h1122_3344);
    chk("postrst_data", bus.word_data, 32'h1122_3344);
    chk("postrst_count", {28'd0, bus.count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
